spi_ram_ctrl: RTL and testbench

Parametrised command-decoded single-port RAM behind the SPI slave, successor to the fixed 256x8 RAM block. It accepts {cmd[1:0], payload} words from the SPI slave on an rx_valid strobe. It holds separate write and read address pointers, with optional post-increment. Read data is returned to the SPI slave through a valid/ready handshake, with configurable read latency and overrun detection.

---
 rtl/spi_ram_ctrl.sv | 99 +++++++++
 tb/tb_spi_ram_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoded single-port RAM behind the SPI slave
// Define SPI_RAM_AUTO_INC_EN to post-increment wr_ptr/rd_ptr on WRITE/READ.
module spi_ram_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    CMD_SET_WR = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_SET_RD = 2'b10,
    CMD_READ   = 2'b11
  } cmd_e;

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] PTR_STEP = '0;
`endif

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              stage_valid;
  logic [DATA_W-1:0] stage_data;
  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic [DATA_W-1:0] mem_word;
  logic              rd_accept;

  assign cmd       = cmd_e'(din[DATA_W+1:DATA_W]);
  assign payload   = din[DATA_W-1:0];
  assign mem_word  = mem[rd_ptr];
  // A read may start on the very edge that completes the previous handshake.
  assign busy      = ((RD_LATENCY == 2) && stage_valid) || (tx_valid && !tx_ready);
  assign rd_accept = rx_valid && (cmd == CMD_READ) && !busy;

  always_ff @(posedge clk) begin
    if (rst_n && rx_valid && (cmd == CMD_WRITE)) begin
      mem[wr_ptr] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dout        <= '0;
      tx_valid    <= 1'b0;
      overrun     <= 1'b0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      if (rx_valid) begin
        case (cmd)
          CMD_SET_WR: wr_ptr <= payload[ADDR_W-1:0];
          CMD_WRITE:  wr_ptr <= wr_ptr + PTR_STEP;
          CMD_SET_RD: rd_ptr <= payload[ADDR_W-1:0];
          CMD_READ: begin
            if (busy) overrun <= 1'b1;
            else      rd_ptr  <= rd_ptr + PTR_STEP;
          end
          default: ;
        endcase
      end

      if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      // Memory is sampled in the command cycle so later writes cannot disturb it.
      if (RD_LATENCY == 2) begin
        stage_valid <= rd_accept;
        if (rd_accept) begin
          stage_data <= mem_word;
        end
        if (stage_valid) begin
          tx_valid <= 1'b1;
          dout     <= stage_data;
        end
      end else if (rd_accept) begin
        tx_valid <= 1'b1;
        dout     <= mem_word;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - random + directed check of spi_ram_ctrl at RD_LATENCY 1 and 2
// Honours SPI_RAM_AUTO_INC_EN the same way the design does.
module tb_spi_ram_ctrl;

  localparam logic [1:0] SET_WR = 2'b00;
  localparam logic [1:0] WRITE  = 2'b01;
  localparam logic [1:0] SET_RD = 2'b10;
  localparam logic [1:0] READ   = 2'b11;

`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] dout_q     [2];
  logic       tx_valid_q [2];
  logic       busy_q     [2];
  logic       overrun_q  [2];

  int n_tests;
  int n_fail;

  spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .RD_LATENCY(1)) dut_lat1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_q[0]), .tx_valid(tx_valid_q[0]), .tx_ready(tx_ready),
    .busy(busy_q[0]), .overrun(overrun_q[0])
  );

  spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .RD_LATENCY(2)) dut_lat2 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_q[1]), .tx_valid(tx_valid_q[1]), .tx_ready(tx_ready),
    .busy(busy_q[1]), .overrun(overrun_q[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: memory contents, pointers and a countdown to each read's delivery.
  logic [7:0] ref_mem [256];
  logic [7:0] m_wr    [2];
  logic [7:0] m_rd    [2];
  bit         m_pend  [2];
  int         m_left  [2];
  logic [7:0] m_pdata [2];
  bit         m_txv   [2];
  logic [7:0] m_dout  [2];
  bit         m_ovr   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 8'h00; m_rd[i] = 8'h00; m_pend[i] = 1'b0; m_left[i] = 0;
      m_pdata[i] = 8'h00; m_txv[i] = 1'b0; m_dout[i] = 8'h00; m_ovr[i] = 1'b0;
    end
  endtask

  function automatic bit model_busy(input int i);
    return m_pend[i] || (m_txv[i] && !tx_ready);
  endfunction

  task automatic model_edge();
    logic [1:0] c;
    logic [7:0] p;
    bit         b;
    bit         ntxv;
    c = din[9:8];
    p = din[7:0];
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      b    = model_busy(i);
      ntxv = m_txv[i] && !tx_ready;
      if (m_pend[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          ntxv = 1'b1; m_dout[i] = m_pdata[i]; m_pend[i] = 1'b0;
        end
      end
      if (rx_valid) begin
        if (c == SET_WR) m_wr[i] = p;
        if (c == WRITE)  m_wr[i] = m_wr[i] + 8'(AUTO_INC);
        if (c == SET_RD) m_rd[i] = p;
        if (c == READ) begin
          if (b) m_ovr[i] = 1'b1;
          else begin
            if (i == 0) begin
              ntxv = 1'b1; m_dout[i] = ref_mem[m_rd[i]];
            end else begin
              m_pend[i] = 1'b1; m_left[i] = 1; m_pdata[i] = ref_mem[m_rd[i]];
            end
            m_rd[i] = m_rd[i] + 8'(AUTO_INC);
          end
        end
      end
      m_txv[i] = ntxv;
    end
    // Both instances see identical writes, so one memory image serves both.
    if (rx_valid && c == WRITE) ref_mem[m_wr[0] - 8'(AUTO_INC)] = p;
  endtask

  task automatic cycle(input bit r, input bit rv, input logic [1:0] c, input logic [7:0] p,
                       input bit rdy);
    rst_n = r; rx_valid = rv; din = {c, p}; tx_ready = rdy;
    #4;
    for (int i = 0; i < 2; i++) check($sformatf("busy%0d", i), busy_q[i], model_busy(i));
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx_valid%0d", i), tx_valid_q[i], m_txv[i]);
      check($sformatf("dout%0d", i), dout_q[i], m_dout[i]);
      check($sformatf("overrun%0d", i), overrun_q[i], m_ovr[i]);
    end
  endtask

  task automatic cmd(input logic [1:0] c, input logic [7:0] p, input bit rdy);
    cycle(1'b1, 1'b1, c, p, rdy);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b1, 1'b0, 2'b00, 8'h00, rdy);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; rx_valid = 1'b1; din = 10'h3FF; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    idle(1'b0);
    for (int i = 0; i < 2; i++) begin
      check("reset_dout", dout_q[i], 8'h00);
      check("reset_tx_valid", tx_valid_q[i], 1'b0);
      check("reset_overrun", overrun_q[i], 1'b0);
      check("reset_busy", busy_q[i], 1'b0);
    end

    for (int a = 0; a < 256; a++) begin
      cmd(SET_WR, 8'(a), 1'($urandom_range(1)));
      cmd(WRITE, 8'(a) ^ 8'h5A, 1'($urandom_range(1)));
    end
    repeat (3) idle(1'b1);

    cmd(SET_WR, 8'h10, 1'b1);
    cmd(WRITE, 8'hA5, 1'b1);
    cmd(SET_RD, 8'h10, 1'b1);
    cmd(READ, 8'h00, 1'b1);
    check("wr_rd_valid", tx_valid_q[0], 1'b1);
    check("wr_rd_dout", dout_q[0], 8'hA5);
    idle(1'b1);
    check("wr_rd_handshake", tx_valid_q[0], 1'b0);
    idle(1'b1);
    check("wr_rd_lat2_dout", dout_q[1], 8'hA5);
    idle(1'b1);

    cmd(SET_WR, 8'hFF, 1'b0);
    cmd(WRITE, 8'h11, 1'b0);
    cmd(WRITE, 8'h22, 1'b0);
    cmd(SET_RD, 8'hFF, 1'b0);
    cmd(READ, 8'h00, 1'b0);
    check("autoinc_first", dout_q[0], AUTO_INC ? 8'h11 : 8'h22);
    idle(1'b1);
    idle(1'b1);
    cmd(READ, 8'h00, 1'b0);
    check("autoinc_second", dout_q[0], 8'h22);
    idle(1'b1);
    idle(1'b1);

    cmd(SET_RD, 8'h10, 1'b0);
    cmd(READ, 8'h00, 1'b0);
    cmd(READ, 8'h00, 1'b0);
    repeat (3) idle(1'b0);
    check("overrun_set", overrun_q[0], 1'b1);
    check("overrun_hold_dout", dout_q[0], 8'hA5);
    idle(1'b1);
    idle(1'b1);
    cmd(READ, 8'h00, 1'b0);
    check("overrun_ptr_once", dout_q[0], AUTO_INC ? 8'h4B : 8'hA5);
    check("overrun_sticky", overrun_q[0], 1'b1);
    idle(1'b1);
    idle(1'b1);

    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    cmd(SET_WR, 8'h05, 1'b0);
    cmd(WRITE, 8'h3C, 1'b0);
    cmd(SET_RD, 8'h05, 1'b0);
    cmd(READ, 8'h00, 1'b0);
    check("lat2_busy_between", busy_q[1], 1'b1);
    check("lat2_not_yet", tx_valid_q[1], 1'b0);
    cmd(READ, 8'h00, 1'b0);
    check("lat2_valid", tx_valid_q[1], 1'b1);
    check("lat2_dout", dout_q[1], 8'h3C);
    check("lat2_overrun", overrun_q[1], 1'b1);
    idle(1'b1);

    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    cmd(SET_RD, 8'h05, 1'b1);
    cmd(READ, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      check("midreset_tx_valid", tx_valid_q[1], 1'b0);
      check("midreset_dout", dout_q[1], 8'h00);
    end

    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(99) != 0), ($urandom_range(9) < 7),
            2'($urandom_range(3)), 8'($urandom), 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
